ghostbus_arb2: RTL and testbench
================================

GHOSTBUS_ARB2 -- requirements
Module: ghostbus_arb2

Interface
REQ-001 SHALL have parameter AW, default 24, ghostbus address width.
REQ-002 SHALL have parameter DW, default 32, ghostbus data width.
REQ-003 SHALL have parameter RD, default 8, ghostbus read latency in cycles; legal range 0..255.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have, for each requester n in {0,1}, ports rn_valid  input  1  request present.
REQ-007 SHALL have rn_ready  output  1  request accepted this cycle.
REQ-008 SHALL have rn_we  input  1  1=write, 0=read.
REQ-009 SHALL have rn_addr  input  AW  target address.
REQ-010 SHALL have rn_wdata  input  DW  write data.
REQ-011 SHALL have rn_resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have rn_rdata  output  DW  read data, valid with rn_resp_valid.
REQ-013 SHALL have gb_addr  output  AW  ghostbus address, registered.
REQ-014 SHALL have gb_wdata  output  DW  ghostbus write data, registered.
REQ-015 SHALL have gb_wen  output  1  ghostbus write strobe, registered.
REQ-016 SHALL have gb_rdata  input  DW  ghostbus read data.
REQ-017 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, WRITE, READ, RESP; one transaction in flight at a time.
REQ-019 SHALL assert rn_ready combinationally only in IDLE, only to the granted requester, only while rn_valid is high; ready never high to both.
REQ-020 SHALL grant round-robin: single valid requester wins; both valid -> requester not served last wins; last-served pointer resets to 1, so requester 0 wins first tie.
REQ-021 SHALL, on handshake at edge T, register addr, wdata, we and owner id; go to WRITE if we=1, else READ.
REQ-022 WRITE: one cycle (T+1) with gb_wen=1, gb_addr/gb_wdata = captured values; then RESP.
REQ-023 READ: gb_addr driven from T+1; down-counter loaded with RD; stays RD+1 cycles (T+1..T+1+RD); on last cycle samples gb_rdata into rdata register; then RESP.
REQ-024 RD=0 SHALL sample gb_rdata in the same cycle the address is first driven (READ lasts 1 cycle).
REQ-025 RESP: one cycle; owner's rn_resp_valid=1, other requester's resp_valid=0; then IDLE.
REQ-026 SHALL present response at T+2 for writes, T+2+RD for reads; next accept no earlier than T+3 (write) / T+3+RD (read).
REQ-027 rn_rdata SHALL hold captured read data until next read completes; writes SHALL leave it unchanged.
REQ-028 gb_addr, gb_wdata SHALL hold last driven value in IDLE; gb_wen SHALL be 0 outside WRITE.
REQ-029 Requester inputs SHALL be ignored outside IDLE; change of rn_addr/rn_wdata after accept SHALL not affect the transaction.
REQ-030 rn_valid dropped without ready SHALL cause no transaction and no pointer update.

Reset
REQ-031 rst high SHALL immediately force: state IDLE, gb_wen 0, gb_addr 0, gb_wdata 0, all resp_valid 0, all rdata 0, counter 0, pointer 1, busy 0, ready 0 while rst high.
REQ-032 rst mid-transaction SHALL abort it: no resp_valid issued for it, no further gb_wen; first acceptance possible in first cycle after rst deasserts.

Verification
REQ-033 r0 write addr 0x000010 data 0xDEADBEEF -> r0_ready at T, gb_wen=1 at T+1 with those values, r0_resp_valid at T+2, r1 untouched.
REQ-034 r1 read addr 0x000020, gb_rdata model returns 0x12345678 exactly 8 cycles after address -> r1_rdata=0x12345678 with r1_resp_valid at T+10; busy high T+1..T+10.
REQ-035 r0 and r1 both valid continuously, 4 writes each -> grants alternate 0,1,0,1,...; exactly one ready per grant; no gb_wen overlap.
REQ-036 Build with RD=0, read 0x000004 against combinational model returning 0xA5A5A5A5 -> resp at T+2 with 0xA5A5A5A5.
REQ-037 Assert rst at T+4 of an RD=8 read -> outputs at reset values same cycle, no resp_valid; new r0 write after release completes normally.

Source files
------------

// File: rtl/ghostbus_arb2_if.sv
// Two-requester front side plus the ghostbus back side of the arbiter.
interface ghostbus_arb2_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          r0_valid, r0_ready, r0_we, r0_resp_valid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_resp_valid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata, gb_rdata;
  logic          gb_wen;
  logic          busy;

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_resp_valid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_ready, r1_resp_valid, r1_rdata,
    output gb_addr, gb_wdata, gb_wen, busy,
    input  gb_rdata
  );

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_resp_valid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_ready, r1_resp_valid, r1_rdata,
    input  gb_addr, gb_wdata, gb_wen, busy,
    output gb_rdata
  );
endinterface

// File: rtl/ghostbus_arb2.sv
// Round-robin arbiter giving two requesters single-outstanding access to a
// fixed-latency ghostbus (one write strobe cycle, or RD+1 read cycles).
module ghostbus_arb2 #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int RD = 8
) (
  input logic            clk,
  input logic            rst,
  ghostbus_arb2_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t               state;
  logic [1:0]           valid, ready, req_we, resp_valid;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][DW-1:0]   req_wdata, rdata;
  logic                 last, owner, grant;
  logic [7:0]           cnt;
  logic [AW-1:0]        gb_addr;
  logic [DW-1:0]        gb_wdata;
  logic                 gb_wen;

  assign valid     = {bus.r1_valid, bus.r0_valid};
  assign req_we    = {bus.r1_we, bus.r0_we};
  assign req_addr  = {bus.r1_addr, bus.r0_addr};
  assign req_wdata = {bus.r1_wdata, bus.r0_wdata};

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = (valid == 2'b11) ? ~last : valid[1];
    ready = 2'b00;
    if (state == IDLE && !rst) ready[grant] = valid[grant];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gb_wen     <= 1'b0;
      gb_addr    <= '0;
      gb_wdata   <= '0;
      resp_valid <= 2'b00;
      rdata      <= '0;
      cnt        <= 8'd0;
      last       <= 1'b1;
      owner      <= 1'b0;
    end else begin
      gb_wen     <= 1'b0;
      resp_valid <= 2'b00;
      case (state)
        IDLE: if (|ready) begin
          owner   <= grant;
          last    <= grant;
          gb_addr <= req_addr[grant];
          if (req_we[grant]) begin
            gb_wdata <= req_wdata[grant];
            gb_wen   <= 1'b1;
            state    <= WRITE;
          end else begin
            cnt   <= 8'(RD);
            state <= READ;
          end
        end
        WRITE: begin
          resp_valid[owner] <= 1'b1;
          state             <= RESP;
        end
        // cnt==0 marks the last of the RD+1 address cycles: sample there.
        READ: if (cnt == 8'd0) begin
          rdata[owner]      <= bus.gb_rdata;
          resp_valid[owner] <= 1'b1;
          state             <= RESP;
        end else begin
          cnt <= cnt - 8'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_ready      = ready[0];
  assign bus.r1_ready      = ready[1];
  assign bus.r0_resp_valid = resp_valid[0];
  assign bus.r1_resp_valid = resp_valid[1];
  assign bus.r0_rdata      = rdata[0];
  assign bus.r1_rdata      = rdata[1];
  assign bus.gb_addr       = gb_addr;
  assign bus.gb_wdata      = gb_wdata;
  assign bus.gb_wen        = gb_wen;
  assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_ghostbus_arb2.sv
// Scoreboard bench: an RD=8 and an RD=0 arbiter run side by side against a
// memory-backed ghostbus responder and a cycle-level reference model.
module tb_ghostbus_arb2;
  localparam int AW = 24;
  localparam int DW = 32;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { int cyc; int owner; logic we; logic [DW-1:0] data; } rsp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endfunction

  // Contents of never-written ghostbus locations.
  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return {8'h5A, a} ^ 32'h0F0F_0F0F;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int RDG = (g == 0) ? 8 : 0;

    logic rst;
    ghostbus_arb2_if #(.AW(AW), .DW(DW)) bus ();
    ghostbus_arb2 #(.AW(AW), .DW(DW), .RD(RDG)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    req_t          pend [2][$];
    rsp_t          rq [$];
    wr_t           wq [$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] held [2];
    logic [1:0]    hs = 2'b00;
    logic          rand_en;
    logic          last = 1'b1;
    logic          ract = 1'b0;
    int            next_ok = 0;
    int            rage = 0;
    bit            fin;

    // Requester driver: presents queued requests, retires them on handshake.
    always @(posedge clk) begin
      logic [1:0] vv;
      req_t       cur [2];
      #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        if (rand_en && pend[i].size() == 0 && $urandom_range(0, 2) == 0)
          pend[i].push_back('{1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom)});
        vv[i] = (pend[i].size() > 0) && !(rand_en && $urandom_range(0, 7) == 0);
        if (pend[i].size() > 0) cur[i] = pend[i][0];
        else cur[i] = '{1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom)};
      end
      bus.r0_valid = vv[0]; bus.r0_we = cur[0].we; bus.r0_addr = cur[0].addr; bus.r0_wdata = cur[0].data;
      bus.r1_valid = vv[1]; bus.r1_we = cur[1].we; bus.r1_addr = cur[1].addr; bus.r1_wdata = cur[1].data;
    end

    // Monitor, reference model and ghostbus responder.
    always @(negedge clk) begin
      logic [1:0]    v, er, rv;
      int            i;
      logic          hwe;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd, rd;
      v  = {bus.r1_valid, bus.r0_valid};
      rv = {bus.r1_resp_valid, bus.r0_resp_valid};
      if (rst) begin
        chk("rst_ready", g, 64'({bus.r1_ready, bus.r0_ready}), 64'(0));
        chk("rst_busy", g, 64'(bus.busy), 64'(0));
        chk("rst_gb", g, 64'({bus.gb_wen, bus.gb_addr, bus.gb_wdata}), 64'(0));
        chk("rst_resp", g, 64'(rv), 64'(0));
        chk("rst_rdata", g, {bus.r1_rdata, bus.r0_rdata}, 64'(0));
        rq.delete(); wq.delete();
        next_ok = 0; last = 1'b1; held[0] = '0; held[1] = '0;
        hs = 2'b00; ract = 1'b0; bus.gb_rdata = '0;
      end else begin
        er = 2'b00;
        if (cyc >= next_ok) er = (v == 2'b11) ? (last ? 2'b01 : 2'b10) : v;
        chk("ready", g, 64'({bus.r1_ready, bus.r0_ready}), 64'(er));
        chk("busy", g, 64'(bus.busy), 64'(cyc < next_ok));

        if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          chk("gb_wen", g, 64'(bus.gb_wen), 64'(1));
          chk("gb_addr_wdata", g, 64'({bus.gb_addr, bus.gb_wdata}), 64'({wq[0].addr, wq[0].data}));
          void'(wq.pop_front());
        end else chk("gb_wen_idle", g, 64'(bus.gb_wen), 64'(0));
        if (bus.gb_wen) bus_mem[bus.gb_addr] = bus.gb_wdata;

        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          chk("resp_valid", g, 64'(rv), 64'(2'b01 << rq[0].owner));
          if (!rq[0].we) held[rq[0].owner] = rq[0].data;
          void'(rq.pop_front());
        end else chk("resp_idle", g, 64'(rv), 64'(0));
        chk("r0_rdata", g, 64'(bus.r0_rdata), 64'(held[0]));
        chk("r1_rdata", g, 64'(bus.r1_rdata), 64'(held[1]));

        hs = v & {bus.r1_ready, bus.r0_ready};
        if (hs != 2'b00) begin
          i = hs[1] ? 1 : 0;
          if (i == 1) begin hwe = bus.r1_we; ha = bus.r1_addr; hd = bus.r1_wdata; end
          else begin hwe = bus.r0_we; ha = bus.r0_addr; hd = bus.r0_wdata; end
          if (hwe) begin
            ref_mem[ha] = hd;
            wq.push_back('{cyc + 1, ha, hd});
            rq.push_back('{cyc + 2, i, 1'b1, '0});
            next_ok = cyc + 3;
          end else begin
            rq.push_back('{cyc + 2 + RDG, i, 1'b0, ref_mem.exists(ha) ? ref_mem[ha] : init_val(ha)});
            next_ok = cyc + 3 + RDG;
            ract = 1'b1;
            rage = 0;
          end
          last = (i == 1);
        end else if (ract) rage++;

        // Read data is only correct in the single cycle the DUT must sample it.
        rd = bus_mem.exists(bus.gb_addr) ? bus_mem[bus.gb_addr] : init_val(bus.gb_addr);
        bus.gb_rdata = (ract && rage == RDG + 1) ? rd : ~rd;
        if (rage > RDG + 1) ract = 1'b0;
      end
    end

    initial begin
      int t0;
      rst = 1'b1;
      rand_en = 1'b0;
      ref_mem[24'h000020] = 32'h1234_5678; bus_mem[24'h000020] = 32'h1234_5678;
      ref_mem[24'h000004] = 32'hA5A5_A5A5; bus_mem[24'h000004] = 32'hA5A5_A5A5;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      pend[0].push_back('{1'b1, 24'h000010, 32'hDEAD_BEEF});
      t0 = 0;
      while ((pend[0].size() + pend[1].size() + rq.size() > 0 || cyc < next_ok) && t0 < 300) begin @(negedge clk); t0++; end
      chk("drain_write", g, 64'(t0 >= 300), 64'(0));

      pend[0].push_back('{1'b0, 24'h000004, 32'h0});
      pend[0].push_back('{1'b0, 24'h000010, 32'h0});
      pend[1].push_back('{1'b0, 24'h000020, 32'h0});
      t0 = 0;
      while ((pend[0].size() + pend[1].size() + rq.size() > 0 || cyc < next_ok) && t0 < 300) begin @(negedge clk); t0++; end
      chk("drain_reads", g, 64'(t0 >= 300), 64'(0));

      for (int k = 0; k < 4; k++) begin
        pend[0].push_back('{1'b1, AW'(24'h000100 + k), DW'(32'hA000_0000 + k)});
        pend[1].push_back('{1'b1, AW'(24'h000200 + k), DW'(32'hB000_0000 + k)});
      end
      t0 = 0;
      while ((pend[0].size() + pend[1].size() + rq.size() > 0 || cyc < next_ok) && t0 < 300) begin @(negedge clk); t0++; end
      chk("drain_tie", g, 64'(t0 >= 300), 64'(0));

      pend[0].push_back('{1'b0, 24'h000020, 32'h0});
      t0 = 0;
      while (rq.size() == 0 && t0 < 50) begin @(negedge clk); t0++; end
      chk("abort_accept", g, 64'(t0 >= 50), 64'(0));
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      pend[0].push_back('{1'b1, 24'h000030, 32'hCAFE_F00D});
      pend[1].push_back('{1'b1, 24'h000031, 32'h0BAD_F00D});
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      t0 = 0;
      while ((pend[0].size() + pend[1].size() + rq.size() > 0 || cyc < next_ok) && t0 < 300) begin @(negedge clk); t0++; end
      chk("drain_after_rst", g, 64'(t0 >= 300), 64'(0));

      rand_en = 1'b1;
      repeat (400) @(posedge clk);
      rand_en = 1'b0;
      t0 = 0;
      while ((pend[0].size() + pend[1].size() + rq.size() > 0 || cyc < next_ok) && t0 < 300) begin @(negedge clk); t0++; end
      chk("drain_random", g, 64'(t0 >= 300), 64'(0));
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    @(negedge clk);
    while (!(inst[0].fin && inst[1].fin) && n < 20000) begin @(negedge clk); n++; end
    chk("finish_timeout", -1, 64'(n >= 20000), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
